// File: rtl/uart_tx_pkg.sv
// Shared UART definitions: line-state encoding, frame width and bit-timing helper.
// Combinational only; no handshake of its own.
package uart_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  localparam int UART_DATA_BITS = 8;

  // Also used by the receiver so both ends derive the same bit period.
  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO for the UART transmitter; pop_data shows the head entry combinationally.
// Pushes into a full FIFO and pops from an empty one are dropped; push+pop together keep the count.
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == (AW+1)'(DEPTH));
  assign pop_data = mem_q[rptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    do_push = push && !full;
    do_pop  = pop && !empty;
    wptr_d  = wptr_q + AW'(do_push);
    rptr_d  = rptr_q + AW'(do_pop);
    count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// Buffered 8N1 UART transmitter: accepted byte reaches the line two edges later, 10 bit periods per frame.
// tx_ready drops only when the FIFO is full; back-to-back frames leave no idle gap.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 12000000,
  parameter int BAUD_RATE   = 115200,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       txd,
  output logic       busy
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD_RATE);
  localparam int BW = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    BIT_LAST  = 3'(UART_DATA_BITS - 1);

  if (CLKS_PER_BIT < 2) begin : g_bad_baud
    $error("uart_tx: CLK_FREQ_HZ / BAUD_RATE must be at least 2");
  end
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("uart_tx: FIFO_DEPTH must be a power of two and at least 2");
  end

  uart_state_e state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          txd_q, txd_d;
  logic          busy_q, busy_d;

  logic          fifo_pop, fifo_empty, fifo_full;
  logic [7:0]    fifo_data;
  logic          baud_done;

  assign tx_ready  = !fifo_full;
  assign txd       = txd_q;
  assign busy      = busy_q;
  assign baud_done = (baud_q == BAUD_LAST);

  uart_tx_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (tx_valid && tx_ready),
    .push_data (tx_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_data),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    fifo_pop = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_data;
          baud_d   = '0;
          bit_d    = '0;
          state_d  = ST_START;
        end
      end
      ST_START: begin
        baud_d = baud_done ? '0 : baud_q + 1'b1;
        if (baud_done) begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        baud_d = baud_done ? '0 : baud_q + 1'b1;
        if (baud_done) begin
          shift_d = shift_q >> 1;
          bit_d   = (bit_q == BIT_LAST) ? 3'd0 : bit_q + 3'd1;
          if (bit_q == BIT_LAST) begin
            state_d = ST_STOP;
          end
        end
      end
      ST_STOP: begin
        baud_d = baud_done ? '0 : baud_q + 1'b1;
        // Chain straight into the next start bit when more data is waiting.
        if (baud_done) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_data;
            bit_d    = '0;
            state_d  = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Line and busy are registered from the current state, so both trail the FSM by one cycle
  // and busy drops exactly when the stop bit leaves the line.
  always_comb begin
    txd_d  = 1'b1;
    busy_d = (state_q != ST_IDLE) || !fifo_empty;
    case (state_q)
      ST_IDLE:  txd_d = 1'b1;
      ST_START: txd_d = 1'b0;
      ST_DATA:  txd_d = shift_q[0];
      ST_STOP:  txd_d = 1'b1;
      default:  txd_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx at 4 clocks per bit with a 4-entry FIFO.
// Expected line and busy traces come from frame start times derived from acceptance times.
module tb_uart_tx;

  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;
  localparam int MAXC  = 20000;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, txd, busy;

  uart_tx #(
    .CLK_FREQ_HZ (12000000),
    .BAUD_RATE   (3000000),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .txd      (txd),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Index E holds the values seen after rising edge number E.
  int   ncyc = 0;
  logic line_a [0:MAXC];
  logic busy_a [0:MAXC];
  logic rdy_a  [0:MAXC];

  always @(negedge clk) begin
    if (ncyc < MAXC) begin
      ncyc             <= ncyc + 1;
      line_a[ncyc + 1] <= txd;
      busy_a[ncyc + 1] <= busy;
      rdy_a[ncyc + 1]  <= tx_ready;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  int         acc_q[$];
  logic [7:0] byte_q[$];
  int         start_q[$];

  typedef struct {
    logic [7:0] data;
    int         lead_low;
    int         ones;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_sb();
    acc_q.delete();
    byte_q.delete();
    start_q.delete();
  endtask

  task automatic push(input logic [7:0] b);
    int tries;
    bit done;
    tries = 0;
    done  = 0;
    tx_data  = b;
    tx_valid = 1'b1;
    while (!done && tries < 400) begin
      if (tx_ready === 1'b1) begin
        @(posedge clk);
        acc_q.push_back(ncyc + 1);
        byte_q.push_back(b);
        done = 1;
      end else begin
        @(negedge clk);
        tries++;
      end
    end
    if (!done) chk("push_timeout", 64'd0, 64'd1);
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // Line level k clocks into a frame: start bit, eight data bits LSB first, stop bit.
  function automatic logic exp_bit(input logic [7:0] b, input int k);
    int s;
    s = k / CPB;
    if (s == 0) return 1'b0;
    if (s >= 9) return 1'b1;
    return b[s-1];
  endfunction

  // A frame reaches the line two edges after acceptance, but never before the previous one ends.
  task automatic build_starts();
    int prev, st;
    start_q.delete();
    prev = -100000;
    foreach (acc_q[i]) begin
      st = acc_q[i] + 2;
      if (prev + FRAME > st) st = prev + FRAME;
      start_q.push_back(st);
      prev = st;
    end
  endtask

  task automatic check_window(input string tag, input int t0, input int t1);
    int   lmis, bmis;
    logic e_txd, e_busy;
    logic [7:0] dec;
    build_starts();
    lmis = 0;
    bmis = 0;
    for (int t = t0; t <= t1; t++) begin
      e_txd  = 1'b1;
      e_busy = 1'b0;
      foreach (start_q[k]) begin
        if (t >= start_q[k] && t < start_q[k] + FRAME) e_txd = exp_bit(byte_q[k], t - start_q[k]);
        if (t >= acc_q[k] + 1 && t <= start_q[k] + FRAME - 1) e_busy = 1'b1;
      end
      if (line_a[t] !== e_txd) lmis++;
      if (busy_a[t] !== e_busy) bmis++;
    end
    chk({tag, "_line_mismatches"}, 64'(lmis), 64'd0);
    chk({tag, "_busy_mismatches"}, 64'(bmis), 64'd0);
    foreach (start_q[k]) begin
      for (int i = 0; i < 8; i++) dec[i] = line_a[start_q[k] + CPB * (i + 1) + 2];
      chk({tag, "_decoded_byte"}, {56'd0, dec}, {56'd0, byte_q[k]});
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n, lead, ones, t0, lows, bhigh, rlow;

    vecs[0] = '{8'h55, 4, 20};
    vecs[1] = '{8'h00, 36, 4};
    vecs[2] = '{8'hFF, 4, 36};
    vecs[3] = '{8'hA5, 4, 20};
    vecs[4] = '{8'h3C, 12, 20};
    vecs[5] = '{8'h80, 32, 8};
    vecs[6] = '{8'h01, 4, 8};
    vecs[7] = '{8'hC3, 4, 20};

    // Reset held with the producer active: outputs stay at their idle values.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tx_valid = ~tx_valid;
      tx_data  = 8'(i + 8'h10);
      #1;
      chk("reset_txd", {63'd0, txd}, 64'd1);
      chk("reset_ready", {63'd0, tx_ready}, 64'd1);
      chk("reset_busy", {63'd0, busy}, 64'd0);
    end
    @(negedge clk);
    tx_valid = 1'b0;
    resetn   = 1'b1;
    #1;
    t0 = ncyc;
    wait_cycles(20);
    lows = 0;
    bhigh = 0;
    for (int t = t0 + 1; t <= ncyc; t++) begin
      if (line_a[t] !== 1'b1) lows++;
      if (busy_a[t] !== 1'b0) bhigh++;
    end
    chk("post_reset_line_activity", 64'(lows), 64'd0);
    chk("post_reset_busy", 64'(bhigh), 64'd0);

    // Single-byte frames from an idle transmitter.
    for (int v = 0; v < 8; v++) begin
      clear_sb();
      @(negedge clk);
      push(vecs[v].data);
      n = acc_q[0];
      wait_cycles(48);
      chk("idle_before_start", {63'd0, line_a[n + 1]}, 64'd1);
      chk("start_edge", {63'd0, line_a[n + 2]}, 64'd0);
      lead = 0;
      for (int t = n + 2; t < n + 2 + FRAME && line_a[t] === 1'b0; t++) lead++;
      chk("lead_low_cycles", 64'(lead), 64'(vecs[v].lead_low));
      ones = 0;
      for (int t = n + 2; t < n + 2 + FRAME; t++) if (line_a[t] === 1'b1) ones++;
      chk("frame_high_cycles", 64'(ones), 64'(vecs[v].ones));
      chk("busy_last_cycle", {63'd0, busy_a[n + 41]}, 64'd1);
      chk("busy_fall", {63'd0, busy_a[n + 42]}, 64'd0);
      check_window("single", n, n + 46);
    end

    // Two bytes on consecutive cycles: frames abut with no idle gap.
    clear_sb();
    @(negedge clk);
    push(8'hA5);
    push(8'h3C);
    n = acc_q[0];
    chk("b2b_second_accept", 64'(acc_q[1] - n), 64'd1);
    wait_cycles(90);
    chk("b2b_stop_bit", {63'd0, line_a[n + 41]}, 64'd1);
    chk("b2b_next_start", {63'd0, line_a[n + 42]}, 64'd0);
    chk("b2b_busy_fall", {63'd0, busy_a[n + 82]}, 64'd0);
    check_window("b2b", n, n + 88);

    // Producer held valid with 0x01..0x06: FIFO fills, sixth byte waits for a pop.
    clear_sb();
    @(negedge clk);
    for (int b = 1; b <= 6; b++) push(8'(b));
    n = acc_q[0];
    chk("ovf_fifth_accept", 64'(acc_q[4] - n), 64'd4);
    chk("ovf_ready_low_when_full", {63'd0, rdy_a[acc_q[4]]}, 64'd0);
    chk("ovf_ready_low_before_pop", {63'd0, rdy_a[n + 40]}, 64'd0);
    chk("ovf_ready_after_pop", {63'd0, rdy_a[n + 41]}, 64'd1);
    chk("ovf_sixth_accept", 64'(acc_q[5] - n), 64'd42);
    wait_cycles(215);
    check_window("ovf", n, n + 246);

    // Random bytes with random gaps, including bursts that fill the FIFO.
    clear_sb();
    @(negedge clk);
    for (int i = 0; i < 14; i++) begin
      int gap;
      gap = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 60);
      repeat (gap) @(negedge clk);
      push(8'($urandom));
    end
    n = acc_q[0];
    wait_cycles(260);
    check_window("random", n, ncyc - 1);

    // Reset during data bit 3 of 0xC3 with two bytes still queued.
    clear_sb();
    @(negedge clk);
    push(8'hC3);
    push(8'h11);
    push(8'h22);
    n = acc_q[0];
    for (int g = 0; g < 100 && ncyc < n + 19; g++) begin
      @(negedge clk);
      #1;
    end
    #1;
    chk("midframe_bit3_low", {63'd0, txd}, 64'd0);
    resetn = 1'b0;
    #1;
    chk("midframe_reset_txd", {63'd0, txd}, 64'd1);
    chk("midframe_reset_busy", {63'd0, busy}, 64'd0);
    chk("midframe_reset_ready", {63'd0, tx_ready}, 64'd1);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    #1;
    t0 = ncyc;
    wait_cycles(120);
    lows = 0;
    bhigh = 0;
    rlow = 0;
    for (int t = t0 + 1; t <= ncyc; t++) begin
      if (line_a[t] !== 1'b1) lows++;
      if (busy_a[t] !== 1'b0) bhigh++;
      if (rdy_a[t] !== 1'b1) rlow++;
    end
    chk("after_reset_no_frames", 64'(lows), 64'd0);
    chk("after_reset_busy", 64'(bhigh), 64'd0);
    chk("after_reset_ready", 64'(rlow), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
